// File: rtl/dm_pkg.sv
// Shared debug-module types: DTM op encoding, DM CSR addresses and sequencer state.
package dm_pkg;

  localparam int unsigned DataCount = 12;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'd0,
    DTM_READ  = 2'd1,
    DTM_WRITE = 2'd2
  } dtm_op_e;

  typedef enum logic [6:0] {
    Data0        = 7'h04,
    Data11       = 7'h0F,
    DMControl    = 7'h10,
    DMStatus     = 7'h11,
    Hartinfo     = 7'h12,
    AbstractCS   = 7'h16,
    Command      = 7'h17,
    AbstractAuto = 7'h18,
    ProgBuf0     = 7'h20,
    SBCS         = 7'h38
  } dm_csr_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StDone
  } state_e;

endpackage

// File: rtl/dm_csr_seq_if.sv
// Command, DMI request/response and read-data signals of the CSR sequencer.
interface dm_csr_seq_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [6:0]  cmd_addr_i;
  logic [3:0]  cmd_count_i;
  logic [31:0] cmd_wdata_i;

  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i;
  logic [6:0]  dmi_req_addr_o;
  logic [1:0]  dmi_req_op_o;
  logic [31:0] dmi_req_data_o;

  logic        dmi_resp_valid_i;
  logic        dmi_resp_ready_o;
  logic [31:0] dmi_resp_data_i;
  logic        dmi_resp_err_i;

  logic        rdata_valid_o;
  logic [31:0] rdata_o;
  logic [3:0]  rdata_idx_o;
  logic        done_o;
  logic        err_o;

  modport slave (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_count_i, cmd_wdata_i,
    input  dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_err_i,
    output cmd_ready_o, dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o,
    output dmi_resp_ready_o, rdata_valid_o, rdata_o, rdata_idx_o, done_o, err_o
  );

  modport master (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_count_i, cmd_wdata_i,
    output dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_err_i,
    input  cmd_ready_o, dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o,
    input  dmi_resp_ready_o, rdata_valid_o, rdata_o, rdata_idx_o, done_o, err_o
  );
endinterface

// File: rtl/dm_csr_seq.sv
// Sequences a multi-register CSR read/write command into single DMI accesses,
// one outstanding request at a time.
module dm_csr_seq
  import dm_pkg::*;
#(
  parameter int unsigned MaxCount  = DataCount,
  parameter bit          ErrOnWrap = 1'b1
) (
  input logic        clk_i,
  input logic        rst_ni,
  dm_csr_seq_if.slave bus
);

  localparam logic [4:0] MaxCnt = 5'(MaxCount);

  state_e      state_q, state_d;
  logic [6:0]  addr_q;
  logic [3:0]  count_q, idx_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [3:0]  ridx_q;

  logic       cmd_fire, resp_fire, reject, more;
  logic [7:0] last_addr;
  logic [3:0] idx_next;

  assign cmd_fire  = bus.cmd_valid_i && (state_q == StIdle);
  assign resp_fire = bus.dmi_resp_valid_i && (state_q == StResp);

  // Range end in 8 bits so a run past 7'h7F is visible rather than wrapping.
  assign last_addr = {1'b0, bus.cmd_addr_i} + {4'b0, bus.cmd_count_i} - 8'd1;
  assign reject    = ErrOnWrap && ((last_addr > 8'h7F) || ({1'b0, bus.cmd_count_i} > MaxCnt));
  assign idx_next  = idx_q + 4'd1;
  assign more      = idx_next < count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (cmd_fire) begin
        if (bus.cmd_count_i == 4'd0 || reject) state_d = StDone;
        else                                   state_d = StReq;
      end
      StReq:  if (bus.dmi_req_ready_i) state_d = StResp;
      StResp: if (resp_fire) begin
        if (bus.dmi_resp_err_i || !more) state_d = StDone;
        else                             state_d = StReq;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ridx_q   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if (cmd_fire) begin
        addr_q  <= bus.cmd_addr_i;
        count_q <= bus.cmd_count_i;
        write_q <= bus.cmd_write_i;
        wdata_q <= bus.cmd_wdata_i;
        idx_q   <= '0;
        err_q   <= (bus.cmd_count_i != 4'd0) && reject;
      end
      if (resp_fire) begin
        if (bus.dmi_resp_err_i) begin
          err_q <= 1'b1;
        end else begin
          idx_q <= idx_next;
          if (!write_q) begin
            rvalid_q <= 1'b1;
            rdata_q  <= bus.dmi_resp_data_i;
            ridx_q   <= idx_q;
          end
        end
      end
    end
  end

  // Request fields are driven only while a request is offered; the bus idles at zero.
  always_comb begin
    bus.cmd_ready_o      = (state_q == StIdle);
    bus.dmi_req_valid_o  = (state_q == StReq);
    bus.dmi_req_addr_o   = '0;
    bus.dmi_req_op_o     = DTM_NOP;
    bus.dmi_req_data_o   = '0;
    bus.dmi_resp_ready_o = (state_q == StResp);
    bus.done_o           = (state_q == StDone);
    bus.err_o            = err_q;
    bus.rdata_valid_o    = rvalid_q;
    bus.rdata_o          = rdata_q;
    bus.rdata_idx_o      = ridx_q;
    if (state_q == StReq) begin
      bus.dmi_req_addr_o = addr_q + {3'b0, idx_q};
      bus.dmi_req_op_o   = write_q ? DTM_WRITE : DTM_READ;
      bus.dmi_req_data_o = wdata_q;
    end
  end

endmodule

// File: tb/tb_dm_csr_seq.sv
// Directed bench for dm_csr_seq: a hand-driven DMI responder with expected values per scenario.
module tb_dm_csr_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_csr_seq_if bus ();
  dm_csr_seq #(.MaxCount(12), .ErrOnWrap(1'b1)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int passed = 0;
  int total  = 0;

  int rd_cnt = 0, done_cnt = 0, req_cnt = 0;
  logic [31:0] rd_data_log [32];
  logic [3:0]  rd_idx_log  [32];

  always @(posedge clk) begin
    if (bus.rdata_valid_o) begin
      if (rd_cnt < 32) begin
        rd_data_log[rd_cnt] <= bus.rdata_o;
        rd_idx_log[rd_cnt]  <= bus.rdata_idx_o;
      end
      rd_cnt <= rd_cnt + 1;
    end
    if (bus.done_o) done_cnt <= done_cnt + 1;
    if (bus.dmi_req_valid_o && bus.dmi_req_ready_i) req_cnt <= req_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [6:0] a, input logic [3:0] c, input logic [31:0] d);
    bus.cmd_valid_i = 1'b1; bus.cmd_write_i = w; bus.cmd_addr_i = a;
    bus.cmd_count_i = c;    bus.cmd_wdata_i = d;
    for (int n = 0; n < 20 && !bus.cmd_ready_o; n++) tick();
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.dmi_req_valid_o) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  // One zero-wait request/response exchange; captures the offered request fields.
  task automatic xfer(input logic [31:0] rd, input logic e,
                      output logic [6:0] a, output logic [1:0] op, output logic [31:0] wd, output bit ok);
    wait_req(ok);
    a = bus.dmi_req_addr_o; op = bus.dmi_req_op_o; wd = bus.dmi_req_data_o;
    if (!ok) return;
    bus.dmi_req_ready_i = 1'b1;
    tick();
    bus.dmi_req_ready_i = 1'b0;
    bus.dmi_resp_valid_i = 1'b1; bus.dmi_resp_data_i = rd; bus.dmi_resp_err_i = e;
    tick();
    bus.dmi_resp_valid_i = 1'b0; bus.dmi_resp_err_i = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    total++; if (bus.cmd_ready_o !== 1'b1) $display("FAIL reset_cmd_ready got %b exp 1", bus.cmd_ready_o); else passed++;
    total++; if (bus.dmi_req_valid_o !== 1'b0) $display("FAIL reset_req_valid got %b exp 0", bus.dmi_req_valid_o); else passed++;
    total++; if (bus.dmi_resp_ready_o !== 1'b0) $display("FAIL reset_resp_ready got %b exp 0", bus.dmi_resp_ready_o); else passed++;
    total++; if ({bus.done_o, bus.err_o, bus.rdata_valid_o} !== 3'b000)
      $display("FAIL reset_done_err_rvalid got %b exp 000", {bus.done_o, bus.err_o, bus.rdata_valid_o}); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    logic [6:0] a; logic [1:0] op; logic [31:0] wd; bit ok;
    int rd0 = rd_cnt, dn0 = done_cnt;
    send_cmd(1'b0, 7'h04, 4'd2, 32'h0);
    xfer(32'hFFFF_FFFB, 1'b0, a, op, wd, ok);
    total++; if (!ok || a !== 7'h04 || op !== 2'd1) $display("FAIL read_req0 got ok=%0d addr=%h op=%0d exp addr=04 op=1", ok, a, op); else passed++;
    total++; if (bus.rdata_valid_o !== 1'b1 || bus.rdata_o !== 32'hFFFF_FFFB || bus.rdata_idx_o !== 4'd0)
      $display("FAIL read_rdata0 got v=%b d=%h i=%0d exp v=1 d=fffffffb i=0", bus.rdata_valid_o, bus.rdata_o, bus.rdata_idx_o); else passed++;
    xfer(32'hFFFF_FFFA, 1'b0, a, op, wd, ok);
    total++; if (!ok || a !== 7'h05) $display("FAIL read_req1 got ok=%0d addr=%h exp 05", ok, a); else passed++;
    total++; if (bus.rdata_valid_o !== 1'b1 || bus.rdata_o !== 32'hFFFF_FFFA || bus.rdata_idx_o !== 4'd1)
      $display("FAIL read_rdata1 got v=%b d=%h i=%0d exp v=1 d=fffffffa i=1", bus.rdata_valid_o, bus.rdata_o, bus.rdata_idx_o); else passed++;
    total++; if (bus.done_o !== 1'b1 || bus.err_o !== 1'b0) $display("FAIL read_done got done=%b err=%b exp 1 0", bus.done_o, bus.err_o); else passed++;
    tick(); tick();
    total++; if (rd_cnt - rd0 != 2 || done_cnt - dn0 != 1)
      $display("FAIL read_pulses got rd=%0d done=%0d exp 2 1", rd_cnt - rd0, done_cnt - dn0); else passed++;
    total++; if (rd_data_log[rd0] !== 32'hFFFF_FFFB || rd_idx_log[rd0+1] !== 4'd1)
      $display("FAIL read_log got d0=%h i1=%0d exp fffffffb 1", rd_data_log[rd0], rd_idx_log[rd0+1]); else passed++;
  endtask

  task automatic test_write_stall();
    bit ok;
    send_cmd(1'b1, 7'h17, 4'd1, 32'h13);
    wait_req(ok);
    total++; if (!ok) $display("FAIL write_req_seen got 0 exp 1"); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.dmi_req_valid_o !== 1'b1 || bus.dmi_req_addr_o !== 7'h17 || bus.dmi_req_op_o !== 2'd2 || bus.dmi_req_data_o !== 32'h13)
        $display("FAIL write_hold%0d got v=%b a=%h op=%0d d=%h exp 1 17 2 13", i, bus.dmi_req_valid_o,
                 bus.dmi_req_addr_o, bus.dmi_req_op_o, bus.dmi_req_data_o); else passed++;
      // A stray error response while a request is pending must be ignored.
      bus.dmi_resp_valid_i = (i == 1); bus.dmi_resp_err_i = (i == 1);
      if (i == 1) begin
        total++; if (bus.dmi_resp_ready_o !== 1'b0) $display("FAIL stray_resp_ready got %b exp 0", bus.dmi_resp_ready_o); else passed++;
      end
      tick();
    end
    bus.dmi_resp_valid_i = 1'b0; bus.dmi_resp_err_i = 1'b0;
    bus.dmi_req_ready_i = 1'b1;
    tick();
    bus.dmi_req_ready_i = 1'b0;
    total++; if (bus.dmi_resp_ready_o !== 1'b1 || bus.dmi_req_valid_o !== 1'b0)
      $display("FAIL write_resp_state got rr=%b rv=%b exp 1 0", bus.dmi_resp_ready_o, bus.dmi_req_valid_o); else passed++;
    bus.dmi_resp_valid_i = 1'b1;
    tick();
    bus.dmi_resp_valid_i = 1'b0;
    total++; if (bus.rdata_valid_o !== 1'b0 || bus.done_o !== 1'b1 || bus.err_o !== 1'b0)
      $display("FAIL write_done got rv=%b done=%b err=%b exp 0 1 0", bus.rdata_valid_o, bus.done_o, bus.err_o); else passed++;
    tick();
  endtask

  task automatic test_wrap();
    int req0 = req_cnt;
    send_cmd(1'b0, 7'h7E, 4'd3, 32'h0);
    total++; if (bus.done_o !== 1'b1 || bus.err_o !== 1'b1 || bus.dmi_req_valid_o !== 1'b0)
      $display("FAIL wrap_done got done=%b err=%b rv=%b exp 1 1 0", bus.done_o, bus.err_o, bus.dmi_req_valid_o); else passed++;
    tick();
    total++; if (bus.cmd_ready_o !== 1'b1 || bus.err_o !== 1'b1 || bus.done_o !== 1'b0)
      $display("FAIL wrap_sticky got rdy=%b err=%b done=%b exp 1 1 0", bus.cmd_ready_o, bus.err_o, bus.done_o); else passed++;
    tick();
    total++; if (req_cnt != req0) $display("FAIL wrap_no_req got %0d exp 0", req_cnt - req0); else passed++;
    send_cmd(1'b0, 7'h00, 4'd13, 32'h0);
    total++; if (bus.done_o !== 1'b1 || bus.err_o !== 1'b1)
      $display("FAIL maxcount_reject got done=%b err=%b exp 1 1", bus.done_o, bus.err_o); else passed++;
    tick();
  endtask

  task automatic test_boundary();
    logic [6:0] a; logic [1:0] op; logic [31:0] wd; bit ok;
    int bad = 0;
    send_cmd(1'b1, 7'h74, 4'd12, 32'hA5A5_0001);
    for (int i = 0; i < 12; i++) begin
      xfer(32'h0, 1'b0, a, op, wd, ok);
      if (!ok || a !== 7'(7'h74 + i) || op !== 2'd2 || wd !== 32'hA5A5_0001) bad++;
    end
    total++; if (bad != 0 || a !== 7'h7F) $display("FAIL boundary_reqs got bad=%0d last=%h exp 0 7f", bad, a); else passed++;
    total++; if (bus.done_o !== 1'b1 || bus.err_o !== 1'b0)
      $display("FAIL boundary_done got done=%b err=%b exp 1 0", bus.done_o, bus.err_o); else passed++;
    tick();
  endtask

  task automatic test_resp_err();
    logic [6:0] a; logic [1:0] op; logic [31:0] wd; bit ok;
    int rd0 = rd_cnt, req0 = req_cnt;
    send_cmd(1'b0, 7'h08, 4'd4, 32'h0);
    xfer(32'h1234_5678, 1'b0, a, op, wd, ok);
    total++; if (bus.rdata_valid_o !== 1'b1 || bus.rdata_o !== 32'h1234_5678)
      $display("FAIL err_rdata0 got v=%b d=%h exp 1 12345678", bus.rdata_valid_o, bus.rdata_o); else passed++;
    xfer(32'hDEAD_BEEF, 1'b1, a, op, wd, ok);
    total++; if (!ok || a !== 7'h09) $display("FAIL err_req1 got ok=%0d addr=%h exp 09", ok, a); else passed++;
    total++; if (bus.rdata_valid_o !== 1'b0 || bus.done_o !== 1'b1 || bus.err_o !== 1'b1)
      $display("FAIL err_abort got rv=%b done=%b err=%b exp 0 1 1", bus.rdata_valid_o, bus.done_o, bus.err_o); else passed++;
    tick(); tick(); tick();
    total++; if (req_cnt - req0 != 2 || rd_cnt - rd0 != 1)
      $display("FAIL err_counts got req=%0d rd=%0d exp 2 1", req_cnt - req0, rd_cnt - rd0); else passed++;
  endtask

  task automatic test_count_zero();
    int req0 = req_cnt;
    send_cmd(1'b0, 7'h10, 4'd0, 32'h0);
    total++; if (bus.done_o !== 1'b1 || bus.err_o !== 1'b0 || bus.dmi_req_valid_o !== 1'b0)
      $display("FAIL zero_done got done=%b err=%b rv=%b exp 1 0 0", bus.done_o, bus.err_o, bus.dmi_req_valid_o); else passed++;
    tick();
    total++; if (bus.done_o !== 1'b0 || bus.cmd_ready_o !== 1'b1)
      $display("FAIL zero_idle got done=%b rdy=%b exp 0 1", bus.done_o, bus.cmd_ready_o); else passed++;
    tick();
    total++; if (req_cnt != req0) $display("FAIL zero_no_req got %0d exp 0", req_cnt - req0); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [6:0] a; logic [1:0] op; logic [31:0] wd; bit ok;
    int dn0;
    send_cmd(1'b0, 7'h04, 4'd2, 32'h0);
    wait_req(ok);
    bus.dmi_req_ready_i = 1'b1;
    tick();
    bus.dmi_req_ready_i = 1'b0;
    total++; if (bus.dmi_resp_ready_o !== 1'b1) $display("FAIL mid_in_resp got %b exp 1", bus.dmi_resp_ready_o); else passed++;
    dn0 = done_cnt;
    rst_n = 1'b0;
    #1;
    total++; if (bus.cmd_ready_o !== 1'b1 || bus.dmi_req_valid_o !== 1'b0 || bus.dmi_resp_ready_o !== 1'b0)
      $display("FAIL mid_rst_hs got rdy=%b rv=%b rr=%b exp 1 0 0", bus.cmd_ready_o, bus.dmi_req_valid_o, bus.dmi_resp_ready_o); else passed++;
    total++; if (bus.done_o !== 1'b0 || bus.err_o !== 1'b0 || bus.rdata_valid_o !== 1'b0 || bus.rdata_o !== 32'h0 || bus.dmi_req_addr_o !== 7'h0)
      $display("FAIL mid_rst_out got done=%b err=%b rv=%b d=%h a=%h exp all 0", bus.done_o, bus.err_o,
               bus.rdata_valid_o, bus.rdata_o, bus.dmi_req_addr_o); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (done_cnt != dn0) $display("FAIL mid_no_done got %0d exp 0", done_cnt - dn0); else passed++;
    send_cmd(1'b0, 7'h05, 4'd1, 32'h0);
    xfer(32'hCAFE_F00D, 1'b0, a, op, wd, ok);
    total++; if (!ok || a !== 7'h05 || bus.rdata_o !== 32'hCAFE_F00D || bus.done_o !== 1'b1 || bus.err_o !== 1'b0)
      $display("FAIL mid_recover got ok=%0d a=%h d=%h done=%b err=%b exp 1 05 cafef00d 1 0", ok, a,
               bus.rdata_o, bus.done_o, bus.err_o); else passed++;
    tick();
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = '0;
    bus.cmd_count_i = '0;   bus.cmd_wdata_i = '0;
    bus.dmi_req_ready_i = 1'b0; bus.dmi_resp_valid_i = 1'b0;
    bus.dmi_resp_data_i = '0;   bus.dmi_resp_err_i = 1'b0;
    test_reset();
    test_read();
    test_write_stall();
    test_wrap();
    test_boundary();
    test_resp_err();
    test_count_zero();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dm_csr_seq.md
DM_CSR_SEQ -- requirements
Module: dm_csr_seq

Interface
REQ-001 Parameter MaxCount, default 12, SHALL set the maximum number of consecutive registers per command.
REQ-002 Parameter ErrOnWrap, default 1, SHALL make the block reject commands whose address range passes 7'h7F.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 cmd_valid_i / cmd_ready_o  in/out  1/1  SHALL be the command handshake; a command is accepted when both are high.
REQ-006 cmd_write_i  input  1  SHALL select a write (1) or a read (0).
REQ-007 cmd_addr_i  input  7  SHALL give the start CSR address, for example Data0 = 7'h04.
REQ-008 cmd_count_i  input  4  SHALL give the number of consecutive registers to access.
REQ-009 cmd_wdata_i  input  32  SHALL give the write data, applied to every address in a write command.
REQ-010 dmi_req_valid_o / dmi_req_ready_i  out/in  1/1  SHALL be the request handshake toward the CSR responder.
REQ-011 dmi_req_addr_o  output  7  SHALL carry the request address.
REQ-012 dmi_req_op_o  output  2  SHALL carry the operation: 2'd1 read, 2'd2 write.
REQ-013 dmi_req_data_o  output  32  SHALL carry the write data.
REQ-014 dmi_resp_valid_i / dmi_resp_ready_o  in/out  1/1  SHALL be the response handshake.
REQ-015 dmi_resp_data_i  input  32  SHALL carry the response data.
REQ-016 dmi_resp_err_i  input  1  SHALL flag a response error.
REQ-017 rdata_valid_o  output  1  SHALL pulse once per read response.
REQ-018 rdata_o  output  32  SHALL carry the read data.
REQ-019 rdata_idx_o  output  4  SHALL carry the offset from the start address.
REQ-020 done_o  output  1  SHALL pulse for one cycle at command completion.
REQ-021 err_o  output  1  SHALL be a sticky error flag, cleared when the next command is accepted.

Function
REQ-022 FSM states SHALL be IDLE, REQ, RESP and DONE, with cmd_ready_o high only in IDLE.
REQ-023 Command acceptance SHALL latch addr, count, op and wdata, clear err_o, and move IDLE->REQ, so that dmi_req_valid_o rises in the following cycle.
REQ-024 cmd_count_i=0 SHALL move IDLE->DONE, issue no request, and pulse done_o one cycle after acceptance.
REQ-025 With ErrOnWrap=1, a command where cmd_addr_i+cmd_count_i-1 > 7'h7F, or cmd_count_i > MaxCount, SHALL move IDLE->DONE with err_o=1 and issue no request; the address sum SHALL be computed in 8 bits.
REQ-026 In REQ, dmi_req_valid_o SHALL stay high with all request fields stable until dmi_req_ready_i, then move to RESP; there SHALL be only one outstanding request.
REQ-027 In RESP, dmi_resp_ready_o SHALL be 1; a response handshake SHALL increment the index and go to REQ if the index < count, otherwise to DONE.
REQ-028 For a read response, rdata_valid_o SHALL pulse the cycle after the handshake, with rdata_o and rdata_idx_o registered.
REQ-029 For a write response, rdata_valid_o SHALL stay 0.
REQ-030 dmi_resp_err_i=1 SHALL set err_o, suppress the rdata_valid_o pulse, abort the remaining accesses and go to DONE.
REQ-031 DONE SHALL last exactly one cycle with done_o=1, then go to IDLE.
REQ-032 A response arriving outside RESP SHALL be ignored, since dmi_resp_ready_o=0.
REQ-033 dmi_req_addr_o SHALL equal the start address plus the index, 7 bits wide; wrap is prevented by REQ-025.

Reset
REQ-034 Assertion of rst_ni SHALL immediately force the state to IDLE and all outputs to 0 except cmd_ready_o, which SHALL be 1 after reset.
REQ-035 Reset mid-command SHALL drop the in-flight request silently, with no done_o and no err_o.

Structure
REQ-036 Package dm_pkg SHALL hold dm_csr_t, the dtm_op_e encoding (nop=0, read=1, write=2) and DataCount.
REQ-037 The design SHALL use no sub-module: a single FSM plus index and data registers.

Verification
REQ-038 Read with addr=7'h04, count=2, zero-wait responder returning 32'hFFFF_FFFB and 32'hFFFF_FFFA SHALL produce two rdata pulses (idx 0 and 1, with those data values), done_o, and err_o=0.
REQ-039 Write with addr=7'h17, count=1, wdata=32'h13, and dmi_req_ready_i low for 3 cycles SHALL hold the request stable for 3 cycles, then issue op=2 addr=7'h17 data=32'h13, then done_o.
REQ-040 Read with addr=7'h7E, count=3 SHALL issue no request and give done_o plus err_o=1 one cycle after acceptance.
REQ-041 Read with count=4 where the 2nd response has err=1 SHALL produce exactly one rdata pulse, then done_o and err_o=1, with no 3rd request.
REQ-042 Reset asserted during RESP SHALL return the block to IDLE with cmd_ready_o=1 and all other outputs 0, and a new command SHALL then complete normally.
REQ-043 A command with count=0 SHALL give done_o the cycle after acceptance, with no dmi request.
